// File: rtl/pkt_edit_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pkt_edit_merge                                             |
// | Description : Applies one edit command per packet: strips leading packet |
// |               words, prepends header words from a side FIFO, or drops    |
// |               the packet. Output is one registered word per cycle with   |
// |               valid/ready flow control.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_pkt / rst_pkt_n         : clock, asynchronous active-low reset     |
// |   ec_msg_fifo_*               : edit-command FIFO (FWFT)                 |
// |   ec_dat_fifo_*               : replacement header-word FIFO (FWFT)      |
// |   pkt_fifo_*                  : packet word + message FIFO (FWFT)        |
// |   out_vld/out_rdy/out_dat/msg : registered output stream                 |
// |   stat_pkt/stat_drop/stat_trunc : packet statistics                      |
// | Configuration                                                            |
// |   PKT_EDIT_STAT_EN : when defined, statistics counters are built;        |
// |                      otherwise the stat outputs are tied to zero.        |
// +--------------------------------------------------------------------------+
module pkt_edit_merge #(
  parameter int DWID    = 256,
  parameter int MSG_WID = 14,
  parameter int ECMWID  = 92
) (
  input  logic               clk_pkt,
  input  logic               rst_pkt_n,
  input  logic               ec_msg_fifo_nempty,
  output logic               ec_msg_fifo_ren,
  input  logic [ECMWID-1:0]  ec_msg_fifo_rdata,
  input  logic               ec_dat_fifo_nempty,
  output logic               ec_dat_fifo_ren,
  input  logic [DWID-1:0]    ec_dat_fifo_rdata,
  input  logic               pkt_fifo_nempty,
  output logic               pkt_fifo_ren,
  input  logic [DWID-1:0]    pkt_fifo_rdata,
  input  logic [MSG_WID-1:0] pkt_fifo_rmsg,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [DWID-1:0]    out_dat,
  output logic [MSG_WID-1:0] out_msg,
  output logic [31:0]        stat_pkt,
  output logic [31:0]        stat_drop,
  output logic [31:0]        stat_trunc
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] STRIP = 3'd2;
  localparam logic [2:0] HDR   = 3'd3;
  localparam logic [2:0] BODY  = 3'd4;
  localparam logic [2:0] DROP  = 3'd5;

  localparam int SOP_B = 13;
  localparam int EOP_B = 12;

  logic [2:0]         state_q, state_d;
  logic [3:0]         strip_left_q, strip_left_d;
  logic [3:0]         hdr_cnt_q, hdr_cnt_d;
  logic [3:0]         hdr_left_q, hdr_left_d;
  logic               stripped_q, stripped_d;
  logic               trunc_q, trunc_d;
  logic               first_q, first_d;
  logic               out_vld_q, out_vld_d;
  logic [DWID-1:0]    out_dat_q, out_dat_d;
  logic [MSG_WID-1:0] out_msg_q, out_msg_d;

  logic               can_emit;
  logic               emit;
  logic [DWID-1:0]    emit_dat;
  logic [MSG_WID-1:0] emit_msg;
  logic [3:0]         cmd_strip;
  logic [3:0]         cmd_hdr;
  logic               unused_cmd_bits;

  assign unused_cmd_bits = ^ec_msg_fifo_rdata[ECMWID-1:9];

  assign cmd_strip = ec_msg_fifo_rdata[3:0];
  assign cmd_hdr   = (ec_msg_fifo_rdata[7:4] > 4'd8) ? 4'd8 : ec_msg_fifo_rdata[7:4];
  // The output register can take a new word if empty or draining this cycle.
  assign can_emit  = !out_vld_q || out_rdy;

  always_comb begin
    state_d         = state_q;
    strip_left_d    = strip_left_q;
    hdr_cnt_d       = hdr_cnt_q;
    hdr_left_d      = hdr_left_q;
    stripped_d      = stripped_q;
    trunc_d         = trunc_q;
    first_d         = first_q;
    ec_msg_fifo_ren = 1'b0;
    ec_dat_fifo_ren = 1'b0;
    pkt_fifo_ren    = 1'b0;
    emit            = 1'b0;
    emit_dat        = '0;
    emit_msg        = '0;
    case (state_q)
      IDLE: begin
        if (ec_msg_fifo_nempty) state_d = CMD;
      end
      CMD: begin
        if (ec_msg_fifo_nempty) begin
          ec_msg_fifo_ren = 1'b1;
          strip_left_d    = cmd_strip;
          hdr_cnt_d       = cmd_hdr;
          hdr_left_d      = cmd_hdr;
          stripped_d      = (cmd_strip != 4'd0);
          trunc_d         = 1'b0;
          first_d         = 1'b1;
          if (ec_msg_fifo_rdata[8])   state_d = DROP;
          else if (cmd_strip != 4'd0) state_d = STRIP;
          else if (cmd_hdr != 4'd0)   state_d = HDR;
          else                        state_d = BODY;
        end else begin
          state_d = IDLE;
        end
      end
      STRIP: begin
        if (pkt_fifo_nempty) begin
          pkt_fifo_ren = 1'b1;
          strip_left_d = strip_left_q - 4'd1;
          // The eop check wins over the count so a packet shorter than or
          // equal to the strip length is always flagged as truncated.
          if (pkt_fifo_rmsg[EOP_B]) begin
            trunc_d = 1'b1;
            state_d = (hdr_cnt_q != 4'd0) ? HDR : IDLE;
          end else if (strip_left_q == 4'd1) begin
            state_d = (hdr_cnt_q != 4'd0) ? HDR : BODY;
          end
        end
      end
      HDR: begin
        if (ec_dat_fifo_nempty && can_emit) begin
          ec_dat_fifo_ren  = 1'b1;
          emit             = 1'b1;
          emit_dat         = ec_dat_fifo_rdata;
          emit_msg[SOP_B]  = (hdr_left_q == hdr_cnt_q);
          hdr_left_d       = hdr_left_q - 4'd1;
          if (hdr_left_q == 4'd1) begin
            // A truncated packet is closed by its last header word.
            emit_msg[EOP_B] = trunc_q;
            state_d         = trunc_q ? IDLE : BODY;
          end
        end
      end
      BODY: begin
        if (pkt_fifo_nempty && can_emit) begin
          pkt_fifo_ren = 1'b1;
          emit         = 1'b1;
          emit_dat     = pkt_fifo_rdata;
          emit_msg     = pkt_fifo_rmsg;
          first_d      = 1'b0;
          if ((hdr_cnt_q != 4'd0) || stripped_q) emit_msg[SOP_B] = 1'b0;
          // With no header, the first surviving word becomes the new start.
          if (first_q && (hdr_cnt_q == 4'd0) && stripped_q) emit_msg[SOP_B] = 1'b1;
          if (pkt_fifo_rmsg[EOP_B]) state_d = IDLE;
        end
      end
      DROP: begin
        if (pkt_fifo_nempty) begin
          pkt_fifo_ren = 1'b1;
          if (pkt_fifo_rmsg[EOP_B]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_msg_d = out_msg_q;
    if (emit) begin
      out_vld_d = 1'b1;
      out_dat_d = emit_dat;
      out_msg_d = emit_msg;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_pkt or negedge rst_pkt_n) begin
    if (!rst_pkt_n) begin
      state_q      <= IDLE;
      strip_left_q <= '0;
      hdr_cnt_q    <= '0;
      hdr_left_q   <= '0;
      stripped_q   <= 1'b0;
      trunc_q      <= 1'b0;
      first_q      <= 1'b0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      out_msg_q    <= '0;
    end else begin
      state_q      <= state_d;
      strip_left_q <= strip_left_d;
      hdr_cnt_q    <= hdr_cnt_d;
      hdr_left_q   <= hdr_left_d;
      stripped_q   <= stripped_d;
      trunc_q      <= trunc_d;
      first_q      <= first_d;
      out_vld_q    <= out_vld_d;
      out_dat_q    <= out_dat_d;
      out_msg_q    <= out_msg_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_msg = out_msg_q;

`ifdef PKT_EDIT_STAT_EN
  logic [31:0] stat_pkt_q, stat_drop_q, stat_trunc_q;
  logic        pkt_evt, drop_evt, trunc_evt;

  assign pkt_evt   = emit && emit_msg[EOP_B];
  assign drop_evt  = (state_q == DROP)  && pkt_fifo_ren && pkt_fifo_rmsg[EOP_B];
  assign trunc_evt = (state_q == STRIP) && pkt_fifo_ren && pkt_fifo_rmsg[EOP_B];

  always_ff @(posedge clk_pkt or negedge rst_pkt_n) begin
    if (!rst_pkt_n) begin
      stat_pkt_q   <= '0;
      stat_drop_q  <= '0;
      stat_trunc_q <= '0;
    end else begin
      if (pkt_evt)   stat_pkt_q   <= stat_pkt_q + 32'd1;
      if (drop_evt)  stat_drop_q  <= stat_drop_q + 32'd1;
      if (trunc_evt) stat_trunc_q <= stat_trunc_q + 32'd1;
    end
  end

  assign stat_pkt   = stat_pkt_q;
  assign stat_drop  = stat_drop_q;
  assign stat_trunc = stat_trunc_q;
`else
  assign stat_pkt   = 32'd0;
  assign stat_drop  = 32'd0;
  assign stat_trunc = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_edit_merge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pkt_edit_merge                                          |
// | Description : Self-checking bench for pkt_edit_merge. FWFT FIFOs are     |
// |               modelled as queues; a packet-level model builds the        |
// |               expected output stream for each command.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pkt_edit_merge;
  localparam int DWID      = 256;
  localparam int MSG_WID   = 14;
  localparam int ECMWID    = 92;
  localparam int SIM_LIMIT = 900000;

  logic               clk_pkt = 1'b0;
  logic               rst_pkt_n = 1'b0;
  logic               ec_msg_fifo_nempty, ec_msg_fifo_ren;
  logic [ECMWID-1:0]  ec_msg_fifo_rdata;
  logic               ec_dat_fifo_nempty, ec_dat_fifo_ren;
  logic [DWID-1:0]    ec_dat_fifo_rdata;
  logic               pkt_fifo_nempty, pkt_fifo_ren;
  logic [DWID-1:0]    pkt_fifo_rdata;
  logic [MSG_WID-1:0] pkt_fifo_rmsg;
  logic               out_vld, out_rdy;
  logic [DWID-1:0]    out_dat;
  logic [MSG_WID-1:0] out_msg;
  logic [31:0]        stat_pkt, stat_drop, stat_trunc;

  always #5 clk_pkt = ~clk_pkt;

  pkt_edit_merge #(.DWID(DWID), .MSG_WID(MSG_WID), .ECMWID(ECMWID)) dut (
    .clk_pkt(clk_pkt), .rst_pkt_n(rst_pkt_n),
    .ec_msg_fifo_nempty(ec_msg_fifo_nempty), .ec_msg_fifo_ren(ec_msg_fifo_ren),
    .ec_msg_fifo_rdata(ec_msg_fifo_rdata),
    .ec_dat_fifo_nempty(ec_dat_fifo_nempty), .ec_dat_fifo_ren(ec_dat_fifo_ren),
    .ec_dat_fifo_rdata(ec_dat_fifo_rdata),
    .pkt_fifo_nempty(pkt_fifo_nempty), .pkt_fifo_ren(pkt_fifo_ren),
    .pkt_fifo_rdata(pkt_fifo_rdata), .pkt_fifo_rmsg(pkt_fifo_rmsg),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_msg(out_msg),
    .stat_pkt(stat_pkt), .stat_drop(stat_drop), .stat_trunc(stat_trunc)
  );

  typedef struct packed {
    logic [DWID-1:0]    dat;
    logic [MSG_WID-1:0] msg;
  } word_t;

  logic [ECMWID-1:0] cmd_q[$];
  logic [DWID-1:0]   hdr_q[$];
  word_t             pkt_q[$];
  word_t             exp_q[$];
  word_t             out_log[$];

  int    checks = 0;
  int    failures = 0;
  int    stall_pct = 0;
  int    empty_pct = 0;
  bit    av_cmd = 1'b1, av_hdr = 1'b1, av_pkt = 1'b1;
  bit    pend_cmd = 1'b0, pend_hdr = 1'b0, pend_pkt = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_out;
  int    exp_pkt = 0, exp_drop = 0, exp_trunc = 0;
  int    cyc = 0;
  bit    lat_arm = 1'b0;
  int    first_pop = -1, first_vld = -1;
  logic [31:0] s_pkt = '0, s_drop = '0, s_trunc = '0;

  task automatic chk(input string name, input logic [DWID-1:0] act, input logic [DWID-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DWID-1:0] rnd_dat();
    logic [DWID-1:0] r;
    for (int i = 0; i < DWID/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_inputs();
    ec_msg_fifo_nempty = av_cmd && (cmd_q.size() > 0);
    ec_msg_fifo_rdata  = (cmd_q.size() > 0) ? cmd_q[0] : '0;
    ec_dat_fifo_nempty = av_hdr && (hdr_q.size() > 0);
    ec_dat_fifo_rdata  = (hdr_q.size() > 0) ? hdr_q[0] : '0;
    pkt_fifo_nempty    = av_pkt && (pkt_q.size() > 0);
    pkt_fifo_rdata     = (pkt_q.size() > 0) ? pkt_q[0].dat : '0;
    pkt_fifo_rmsg      = (pkt_q.size() > 0) ? pkt_q[0].msg : '0;
  endtask

  // Queue one command with its packet (and header words), and append the
  // words the block must produce for it to the expected stream.
  task automatic send(input int s, input int h, input bit d, input int n,
                      input bit fixed, input int base);
    logic [95:0]        raw;
    logic [ECMWID-1:0]  c;
    word_t              w[$];
    logic [DWID-1:0]    hw[$];
    logic [DWID-1:0]    hd;
    word_t              t;
    logic [MSG_WID-1:0] m;
    int                 hc;
    bit                 trunc;
    raw    = {$urandom, $urandom, $urandom};
    c      = raw[ECMWID-1:0];
    c[3:0] = s[3:0];
    c[7:4] = h[3:0];
    c[8]   = d;
    hc     = (h > 8) ? 8 : h;
    for (int i = 0; i < n; i++) begin
      if (fixed) begin
        t.dat = DWID'(base + i);
        t.msg = (i == n-1) ? 14'h1051 : 14'h0040;
      end else begin
        t.dat = rnd_dat();
        t.msg = MSG_WID'($urandom);
      end
      t.msg[13] = (i == 0);
      t.msg[12] = (i == n-1);
      w.push_back(t);
      pkt_q.push_back(t);
    end
    if (!d) begin
      for (int j = 0; j < hc; j++) begin
        hd = fixed ? DWID'(base + 'h80 + j) : rnd_dat();
        hw.push_back(hd);
        hdr_q.push_back(hd);
      end
    end
    cmd_q.push_back(c);
    if (d) begin
      exp_drop++;
    end else begin
      trunc = (s >= n);
      for (int j = 0; j < hc; j++) begin
        m = '0;
        m[13] = (j == 0);
        m[12] = trunc && (j == hc-1);
        t.dat = hw[j];
        t.msg = m;
        exp_q.push_back(t);
      end
      if (trunc) begin
        exp_trunc++;
        if (hc > 0) exp_pkt++;
      end else begin
        for (int j = s; j < n; j++) begin
          t = w[j];
          if (hc > 0 || s > 0) t.msg[13] = 1'b0;
          if (j == s && hc == 0 && s > 0) t.msg[13] = 1'b1;
          exp_q.push_back(t);
        end
        exp_pkt++;
      end
    end
  endtask

  task automatic monitor();
    word_t w;
    chk("one_ren", int'(ec_msg_fifo_ren) + int'(ec_dat_fifo_ren) + int'(pkt_fifo_ren) <= 1, 1);
    if (ec_msg_fifo_ren) begin chk("cmd_ren_nonempty", ec_msg_fifo_nempty, 1); pend_cmd = 1'b1; end
    if (ec_dat_fifo_ren) begin chk("hdr_ren_nonempty", ec_dat_fifo_nempty, 1); pend_hdr = 1'b1; end
    if (pkt_fifo_ren)    begin chk("pkt_ren_nonempty", pkt_fifo_nempty, 1);    pend_pkt = 1'b1; end
    if (prev_stall) begin
      chk("stall_vld", out_vld, 1);
      chk("stall_dat", out_dat, prev_out.dat);
      chk("stall_msg", out_msg, prev_out.msg);
    end
    prev_stall   = out_vld && !out_rdy;
    prev_out.dat = out_dat;
    prev_out.msg = out_msg;
    if (lat_arm) begin
      if (pkt_fifo_ren && first_pop < 0) first_pop = cyc;
      if (out_vld && first_vld < 0) first_vld = cyc;
    end
    if (out_vld && out_rdy) begin
      w.dat = out_dat;
      w.msg = out_msg;
      out_log.push_back(w);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        chk("out_dat", out_dat, exp_q[0].dat);
        chk("out_msg", out_msg, exp_q[0].msg);
        exp_q.delete(0);
      end
    end
  endtask

  // FIFO pops take effect after the edge at which ren was seen; outputs and
  // ren are sampled one time unit before the rising edge.
  initial begin : io_proc
    forever begin
      @(negedge clk_pkt);
      if (pend_cmd && cmd_q.size() > 0) cmd_q.delete(0);
      if (pend_hdr && hdr_q.size() > 0) hdr_q.delete(0);
      if (pend_pkt && pkt_q.size() > 0) pkt_q.delete(0);
      pend_cmd = 1'b0;
      pend_hdr = 1'b0;
      pend_pkt = 1'b0;
      av_cmd  = ($urandom_range(99) >= empty_pct);
      av_hdr  = ($urandom_range(99) >= empty_pct);
      av_pkt  = ($urandom_range(99) >= empty_pct);
      out_rdy = ($urandom_range(99) >= stall_pct);
      drive_inputs();
      #4;
      cyc++;
      if (rst_pkt_n) monitor();
    end
  end

  task automatic drain(input string name);
    int k = 0;
    while ((cmd_q.size() > 0 || pkt_q.size() > 0 || hdr_q.size() > 0 ||
            exp_q.size() > 0 || out_vld) && k < 20000) begin
      @(negedge clk_pkt);
      k++;
    end
    chk({name, "_drain_timeout"}, k < 20000, 1);
    repeat (3) @(negedge clk_pkt);
    #1;
  endtask

  task automatic snap();
    s_pkt   = stat_pkt;
    s_drop  = stat_drop;
    s_trunc = stat_trunc;
  endtask

  task automatic stat_chk(input string name, input int dp, input int dd, input int dt);
`ifdef PKT_EDIT_STAT_EN
    chk({name, "_stat_pkt"},   stat_pkt - s_pkt,     dp);
    chk({name, "_stat_drop"},  stat_drop - s_drop,   dd);
    chk({name, "_stat_trunc"}, stat_trunc - s_trunc, dt);
`else
    chk({name, "_stat_pkt"},   stat_pkt,   0);
    chk({name, "_stat_drop"},  stat_drop,  0);
    chk({name, "_stat_trunc"}, stat_trunc, 0);
`endif
  endtask

  task automatic start_test();
    out_log.delete();
    snap();
  endtask

  initial begin : main
    int k;
    out_rdy = 1'b1;
    drive_inputs();
    @(negedge clk_pkt);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_rens", {ec_msg_fifo_ren, ec_dat_fifo_ren, pkt_fifo_ren}, 0);
    chk("rst_stats", {stat_pkt, stat_drop, stat_trunc}, 0);
    @(negedge clk_pkt);
    #2 rst_pkt_n = 1'b1;
    @(negedge clk_pkt);
    #1;

    // Pass-through, 3 words, one-cycle latency.
    start_test();
    first_pop = -1; first_vld = -1; lat_arm = 1'b1;
    send(0, 0, 0, 3, 1, 'h01);
    drain("t_pass");
    lat_arm = 1'b0;
    chk("t_pass_count", out_log.size(), 3);
    chk("t_pass_w0_dat", out_log[0].dat, 'h01);
    chk("t_pass_w0_msg", out_log[0].msg, 14'h2040);
    chk("t_pass_w2_msg", out_log[2].msg, 14'h1051);
    chk("t_pass_latency", first_vld - first_pop, 1);
    stat_chk("t_pass", 1, 0, 0);

    // Single-word sop+eop packet.
    start_test();
    send(0, 0, 0, 1, 1, 'h40);
    drain("t_single");
    chk("t_single_count", out_log.size(), 1);
    chk("t_single_dat", out_log[0].dat, 'h40);
    chk("t_single_msg", out_log[0].msg, 14'h3051);

    // Strip 2, prepend 3 on a 5-word packet.
    start_test();
    send(2, 3, 0, 5, 1, 'h00);
    drain("t_edit");
    chk("t_edit_count", out_log.size(), 6);
    chk("t_edit_h0_dat", out_log[0].dat, 'h80);
    chk("t_edit_h0_msg", out_log[0].msg, 14'h2000);
    chk("t_edit_h1_msg", out_log[1].msg, 14'h0000);
    chk("t_edit_h2_dat", out_log[2].dat, 'h82);
    chk("t_edit_p2_dat", out_log[3].dat, 'h02);
    chk("t_edit_p2_msg", out_log[3].msg, 14'h0040);
    chk("t_edit_p4_dat", out_log[5].dat, 'h04);
    chk("t_edit_p4_msg", out_log[5].msg, 14'h1051);
    stat_chk("t_edit", 1, 0, 0);

    // Drop then pass-through.
    start_test();
    send(0, 0, 1, 4, 1, 'h10);
    send(0, 0, 0, 2, 1, 'h20);
    drain("t_drop");
    chk("t_drop_count", out_log.size(), 2);
    chk("t_drop_w0_dat", out_log[0].dat, 'h20);
    chk("t_drop_w0_msg", out_log[0].msg, 14'h2040);
    chk("t_drop_w1_msg", out_log[1].msg, 14'h1051);
    stat_chk("t_drop", 1, 1, 0);

    // Strip longer than packet: truncation closed by header.
    start_test();
    send(4, 2, 0, 2, 1, 'h30);
    drain("t_trunc");
    chk("t_trunc_count", out_log.size(), 2);
    chk("t_trunc_h0_dat", out_log[0].dat, 'hB0);
    chk("t_trunc_h0_msg", out_log[0].msg, 14'h2000);
    chk("t_trunc_h1_msg", out_log[1].msg, 14'h1000);
    stat_chk("t_trunc", 1, 0, 1);

    // Strip without header: first surviving word gets sop.
    start_test();
    send(1, 0, 0, 3, 1, 'h50);
    drain("t_strip");
    chk("t_strip_count", out_log.size(), 2);
    chk("t_strip_w0_dat", out_log[0].dat, 'h51);
    chk("t_strip_w0_msg", out_log[0].msg, 14'h2040);

    // Header count above 8 is clamped.
    start_test();
    send(0, 12, 0, 1, 1, 'h60);
    drain("t_clamp");
    chk("t_clamp_count", out_log.size(), 9);
    chk("t_clamp_h0_msg", out_log[0].msg, 14'h2000);
    chk("t_clamp_p0_dat", out_log[8].dat, 'h60);
    chk("t_clamp_p0_msg", out_log[8].msg, 14'h1051);

    // Randomized traffic with stalls and FIFO gaps.
    start_test();
    exp_pkt = 0; exp_drop = 0; exp_trunc = 0;
    stall_pct = 30;
    empty_pct = 30;
    for (int p = 0; p < 150; p++) begin
      send(($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(2)),
           ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(3)),
           ($urandom_range(9) == 0), int'($urandom_range(1, 10)), 1'b0, 0);
    end
    drain("t_rand");
    stat_chk("t_rand", exp_pkt, exp_drop, exp_trunc);
    stall_pct = 0;
    empty_pct = 0;

    // Reset in the middle of a body.
    start_test();
    send(0, 0, 0, 8, 0, 0);
    k = 0;
    while (out_log.size() < 3 && k < 200) begin
      @(negedge clk_pkt);
      k++;
    end
    chk("t_rst_reach_body", k < 200, 1);
    @(negedge clk_pkt);
    #2 rst_pkt_n = 1'b0;
    #1;
    chk("t_rst_out_vld", out_vld, 0);
    chk("t_rst_out_dat", out_dat, 0);
    chk("t_rst_out_msg", out_msg, 0);
    chk("t_rst_rens", {ec_msg_fifo_ren, ec_dat_fifo_ren, pkt_fifo_ren}, 0);
    chk("t_rst_stats", {stat_pkt, stat_drop, stat_trunc}, 0);
    cmd_q.delete();
    hdr_q.delete();
    pkt_q.delete();
    exp_q.delete();
    pend_cmd = 1'b0; pend_hdr = 1'b0; pend_pkt = 1'b0;
    prev_stall = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk_pkt);
    #2 rst_pkt_n = 1'b1;
    @(negedge clk_pkt);
    #1;
    start_test();
    send(1, 1, 0, 3, 1, 'h70);
    drain("t_after_rst");
    chk("t_after_rst_count", out_log.size(), 3);
    chk("t_after_rst_h0_dat", out_log[0].dat, 'hF0);
    chk("t_after_rst_h0_msg", out_log[0].msg, 14'h2000);
    chk("t_after_rst_p1_dat", out_log[1].dat, 'h71);
    chk("t_after_rst_p1_msg", out_log[1].msg, 14'h0040);
    chk("t_after_rst_p2_msg", out_log[2].msg, 14'h1051);
    stat_chk("t_after_rst", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #(SIM_LIMIT);
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
